// File: rtl/ysyx_22041412_csr_ctrl.sv
// Issue/complete controller for SYSTEM instructions: decodes one instruction,
// runs the CSR file request/acknowledge handshake and returns a completion record.
module ysyx_22041412_csr_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [63:0] pc,
    input  logic [63:0] rs1_data,
    output logic        csr_en,
    output logic [2:0]  csr_addr,
    output logic [2:0]  csr_func3,
    output logic [63:0] csr_wdata,
    output logic [63:0] csr_pc,
    output logic        csr_valid,
    input  logic        csr_ready,
    input  logic [63:0] csr_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        wb_wen,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        redirect,
    output logic [63:0] redirect_pc,
    output logic        illegal
);

    localparam logic [6:0]  OPC_SYSTEM  = 7'b1110011;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        KIND_CSR,
        KIND_ECALL,
        KIND_MRET,
        KIND_ILLEGAL
    } kind_t;

    state_t      state;
    state_t      state_next;

    kind_t       kind_q;
    logic [2:0]  idx_q;
    logic [2:0]  func3_q;
    logic [63:0] wdata_q;
    logic [63:0] pc_q;
    logic [4:0]  rd_q;
    logic [63:0] result_q;

    kind_t       dec_kind;
    logic [2:0]  dec_idx;
    logic [2:0]  dec_func3;
    logic [63:0] dec_wdata;
    logic [4:0]  dec_rd;
    logic        dec_hit;

    // func3 000 and 100 carry no CSR operation, so only the other six reach the CSR map.
    always_comb begin
        dec_kind  = KIND_ILLEGAL;
        dec_idx   = 3'd0;
        dec_func3 = 3'b000;
        dec_wdata = 64'd0;
        dec_rd    = 5'd0;
        dec_hit   = 1'b0;
        if (inst == INST_ECALL) begin
            dec_kind = KIND_ECALL;
            dec_idx  = 3'd1;
        end else if (inst == INST_MRET) begin
            dec_kind = KIND_MRET;
            dec_idx  = 3'd0;
        end else if (inst[6:0] == OPC_SYSTEM && inst[13:12] != 2'b00) begin
            dec_hit = 1'b1;
            case (inst[31:20])
                CSR_MSTATUS: dec_idx = 3'd2;
                CSR_MTVEC:   dec_idx = 3'd3;
                CSR_MEPC:    dec_idx = 3'd4;
                CSR_MCAUSE:  dec_idx = 3'd5;
                default:     dec_hit = 1'b0;
            endcase
            if (dec_hit) begin
                dec_kind  = KIND_CSR;
                dec_func3 = inst[14:12];
                dec_rd    = inst[11:7];
                dec_wdata = inst[14] ? {59'd0, inst[19:15]} : rs1_data;
            end else begin
                dec_idx = 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (dec_kind == KIND_ILLEGAL) ? DONE : REQ;
                end
            end
            REQ: begin
                if (csr_ready) begin
                    state_next = ACK;
                end
            end
            ACK:  state_next = DONE;
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The result is captured only in ACK; the CSR file drops its data afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q   <= KIND_CSR;
            idx_q    <= 3'd0;
            func3_q  <= 3'd0;
            wdata_q  <= 64'd0;
            pc_q     <= 64'd0;
            rd_q     <= 5'd0;
            result_q <= 64'd0;
        end else if (state == IDLE && in_valid) begin
            kind_q   <= dec_kind;
            idx_q    <= dec_idx;
            func3_q  <= dec_func3;
            wdata_q  <= dec_wdata;
            pc_q     <= pc;
            rd_q     <= dec_rd;
            result_q <= 64'd0;
        end else if (state == ACK) begin
            result_q <= csr_rdata;
        end
    end

    always_comb begin
        in_ready    = (state == IDLE);
        csr_en      = (state == REQ) || (state == ACK);
        csr_valid   = (state == ACK);
        csr_addr    = idx_q;
        csr_func3   = func3_q;
        csr_wdata   = wdata_q;
        csr_pc      = pc_q;
        out_valid   = (state == DONE);
        wb_rd       = rd_q;
        wb_wen      = 1'b0;
        wb_data     = 64'd0;
        redirect    = 1'b0;
        redirect_pc = 64'd0;
        illegal     = 1'b0;
        if (state == DONE) begin
            case (kind_q)
                KIND_CSR: begin
                    wb_wen  = (rd_q != 5'd0);
                    wb_data = result_q;
                end
                KIND_ECALL, KIND_MRET: begin
                    redirect    = 1'b1;
                    redirect_pc = result_q;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_csr_ctrl.sv
// Bench for ysyx_22041412_csr_ctrl: a behavioural CSR file answers the handshake,
// and a CSR-number-keyed reference model predicts every completion record.
module tb_ysyx_22041412_csr_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst = 32'd0;
    logic [63:0] pc = 64'd0;
    logic [63:0] rs1_data = 64'd0;
    logic        csr_en;
    logic [2:0]  csr_addr;
    logic [2:0]  csr_func3;
    logic [63:0] csr_wdata;
    logic [63:0] csr_pc;
    logic        csr_valid;
    logic        csr_ready = 1'b0;
    logic [63:0] csr_rdata = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        illegal;

    ysyx_22041412_csr_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .rs1_data(rs1_data),
        .csr_en(csr_en), .csr_addr(csr_addr), .csr_func3(csr_func3),
        .csr_wdata(csr_wdata), .csr_pc(csr_pc), .csr_valid(csr_valid),
        .csr_ready(csr_ready), .csr_rdata(csr_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        legal;
        logic        is_csr;
        logic        trap;
        logic [2:0]  idx;
        logic [2:0]  f3;
        logic [63:0] wdata;
        logic [63:0] pc;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wdat;
        logic [63:0] rpc;
    } exp_t;

    int checks = 0;
    int errors = 0;

    logic [63:0] file_csr [0:7];
    int          resp_lat = 0;
    int          wait_cnt = 0;
    logic [63:0] ref_csr [int];

    function automatic int idxOf(input int num);
        case (num)
            'h300:   return 2;
            'h305:   return 3;
            'h341:   return 4;
            'h342:   return 5;
            default: return 7;
        endcase
    endfunction

    function automatic logic [31:0] mkCsr(input logic [11:0] c, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {c, r1, f3, rd, 7'h73};
    endfunction

    // Environment CSR file: raises ready after resp_lat REQ cycles, commits in ACK,
    // and drops its data once the acknowledge is gone.
    always @(negedge clk) begin
        if (rst) begin
            csr_ready = 1'b0;
            csr_rdata = 64'd0;
            wait_cnt  = 0;
        end else if (csr_en && !csr_valid) begin
            if (!csr_ready) begin
                if (wait_cnt >= resp_lat) begin
                    csr_ready = 1'b1;
                    case (csr_addr)
                        3'd0:    csr_rdata = file_csr[4];
                        3'd1:    csr_rdata = file_csr[3];
                        default: csr_rdata = file_csr[csr_addr];
                    endcase
                end else begin
                    wait_cnt++;
                end
            end
        end else if (csr_en && csr_valid) begin
            if (csr_ready) begin
                if (csr_addr == 3'd1) begin
                    file_csr[4] = csr_pc;
                    file_csr[5] = 64'hb;
                end else if (csr_addr >= 3'd2 && csr_func3 != 3'd0) begin
                    case (csr_func3[1:0])
                        2'b01:   file_csr[csr_addr] = csr_wdata;
                        2'b10:   file_csr[csr_addr] = file_csr[csr_addr] | csr_wdata;
                        2'b11:   file_csr[csr_addr] = file_csr[csr_addr] & ~csr_wdata;
                        default: ;
                    endcase
                end
            end
        end else begin
            csr_ready = 1'b0;
            csr_rdata = 64'd0;
            wait_cnt  = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic setCsr(input int num, input logic [63:0] val);
        file_csr[idxOf(num)] = val;
        ref_csr[num] = val;
    endtask

    // Reference model: architectural effect of one SYSTEM instruction on the CSR map.
    task automatic modelStep(input logic [31:0] i, input logic [63:0] r,
                             input logic [63:0] p, output exp_t e);
        int          num;
        logic [63:0] opnd;
        logic [63:0] old;
        e     = '0;
        num   = int'(i[31:20]);
        e.pc  = p;
        if (i == 32'h0000_0073) begin
            e.legal = 1; e.trap = 1; e.idx = 3'd1;
            e.rpc = ref_csr['h305];
            ref_csr['h341] = p;
            ref_csr['h342] = 64'hb;
        end else if (i == 32'h3020_0073) begin
            e.legal = 1; e.trap = 1; e.idx = 3'd0;
            e.rpc = ref_csr['h341];
        end else if (i[6:0] == 7'h73 && i[14:12] != 3'd0 && i[14:12] != 3'd4
                     && idxOf(num) != 7) begin
            opnd = i[14] ? 64'(i[19:15]) : r;
            old  = ref_csr[num];
            e.legal = 1; e.is_csr = 1;
            e.idx = 3'(idxOf(num));
            e.f3 = i[14:12];
            e.wdata = opnd;
            e.rd = i[11:7];
            e.wen = (i[11:7] != 5'd0);
            e.wdat = old;
            if (i[13:12] == 2'b01)      ref_csr[num] = opnd;
            else if (i[13:12] == 2'b10) ref_csr[num] = old | opnd;
            else                        ref_csr[num] = old & ~opnd;
        end
    endtask

    task automatic checkRecord(input exp_t e);
        checkOutput("out_valid", out_valid, 1);
        checkOutput("in_ready_busy", in_ready, 0);
        checkOutput("csr_en_done", csr_en, 0);
        checkOutput("wb_wen", wb_wen, e.wen);
        checkOutput("redirect", redirect, e.trap);
        checkOutput("illegal", illegal, !e.legal);
        if (e.is_csr) begin
            checkOutput("wb_rd", wb_rd, e.rd);
            checkOutput("wb_data", wb_data, e.wdat);
        end
        if (e.trap) checkOutput("redirect_pc", redirect_pc, e.rpc);
    endtask

    task automatic checkFile();
        checkOutput("mstatus", file_csr[2], ref_csr['h300]);
        checkOutput("mtvec", file_csr[3], ref_csr['h305]);
        checkOutput("mepc", file_csr[4], ref_csr['h341]);
        checkOutput("mcause", file_csr[5], ref_csr['h342]);
    endtask

    // One full transaction; called at a negedge, returns at a negedge.
    task automatic applyStimulus(input logic [31:0] i, input logic [63:0] r,
                                 input logic [63:0] p, input int lat, input int hold);
        exp_t e;
        int   w = 0;
        int   cyc = 0;
        int   en_cyc = 0;
        int   val_cyc = 0;
        bit   done = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput("in_ready_wait", in_ready, 1);
        modelStep(i, r, p, e);
        resp_lat = lat;
        inst = i; rs1_data = r; pc = p; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        inst = $urandom;
        rs1_data = {$urandom, $urandom};
        pc = {$urandom, $urandom};
        while (cyc < 60 && !done) begin
            @(negedge clk);
            cyc++;
            if (csr_en) begin
                en_cyc++;
                checkOutput("csr_addr", csr_addr, e.idx);
                checkOutput("csr_func3", csr_func3, e.f3);
                checkOutput("csr_wdata", csr_wdata, e.wdata);
                checkOutput("csr_pc", csr_pc, e.pc);
            end
            if (csr_valid) val_cyc++;
            if (out_valid) done = 1;
        end
        checkOutput("completion_timeout", done, 1);
        checkOutput("latency", cyc, e.legal ? 3 + lat : 1);
        checkOutput("csr_en_cycles", en_cyc, e.legal ? lat + 2 : 0);
        checkOutput("csr_valid_cycles", val_cyc, e.legal ? 1 : 0);
        for (int h = 0; h <= hold; h++) begin
            checkRecord(e);
            if (h < hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("in_ready_after", in_ready, 1);
        checkOutput("out_valid_after", out_valid, 0);
        checkFile();
    endtask

    initial begin
        logic [11:0] legal_csr [4];
        logic [2:0]  legal_f3 [6];
        legal_csr = '{12'h300, 12'h305, 12'h341, 12'h342};
        legal_f3  = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        for (int k = 0; k < 8; k++) file_csr[k] = 64'd0;
        setCsr('h300, 64'h0); setCsr('h305, 64'h0);
        setCsr('h341, 64'h0); setCsr('h342, 64'h0);

        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_csr_en", csr_en, 0);
        checkOutput("rst_csr_valid", csr_valid, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_wb_wen", wb_wen, 0);
        checkOutput("rst_redirect", redirect, 0);
        checkOutput("rst_illegal", illegal, 0);
        checkOutput("rst_csr_addr", csr_addr, 0);
        checkOutput("rst_csr_wdata", csr_wdata, 0);
        checkOutput("rst_csr_pc", csr_pc, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed sequence");
        setCsr('h300, 64'ha00001800);
        applyStimulus(mkCsr(12'h300, 5'd6, 3'b001, 5'd5), 64'h8, 64'h80000000, 0, 0);
        setCsr('h305, 64'h80000100);
        applyStimulus(mkCsr(12'h305, 5'd3, 3'b110, 5'd7), 64'hffff, 64'h80000004, 0, 1);
        setCsr('h305, 64'h80000100);
        applyStimulus(32'h0000_0073, 64'h1234, 64'h80000040, 0, 0);
        setCsr('h341, 64'h80000044);
        applyStimulus(32'h3020_0073, 64'h0, 64'h80000100, 0, 0);
        applyStimulus(mkCsr(12'h7c0, 5'd2, 3'b001, 5'd1), 64'h55, 64'h80000048, 0, 0);
        applyStimulus(mkCsr(12'h342, 5'd3, 3'b011, 5'd0), 64'h3, 64'h8000004c, 1, 0);
        applyStimulus(mkCsr(12'h300, 5'd9, 3'b010, 5'd10), 64'h80, 64'h80000050, 2, 4);

        // Reset while the request is outstanding must abandon the transaction.
        resp_lat = 5;
        inst = mkCsr(12'h300, 5'd1, 3'b001, 5'd4);
        rs1_data = 64'hdead;
        pc = 64'h80000060;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("req_csr_en", csr_en, 1);
        checkOutput("req_csr_valid", csr_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_csr_en", csr_en, 0);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_csr_wdata", csr_wdata, 0);
        rst = 1'b0;
        @(negedge clk);
        checkFile();

        $display("[TB] randomized sequence");
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ri;
            logic [11:0] c;
            int          sel;
            sel = $urandom_range(0, 9);
            c = legal_csr[$urandom_range(0, 3)];
            if (sel <= 4) begin
                ri = mkCsr(c, 5'($urandom), legal_f3[$urandom_range(0, 5)], 5'($urandom));
            end else if (sel == 5) begin
                ri = 32'h0000_0073;
            end else if (sel == 6) begin
                ri = 32'h3020_0073;
            end else if (sel == 7) begin
                c = 12'($urandom);
                if (idxOf(int'(c)) != 7) c = c ^ 12'h800;
                ri = mkCsr(c, 5'($urandom), legal_f3[$urandom_range(0, 5)], 5'($urandom));
            end else if (sel == 8) begin
                ri = mkCsr(c, 5'($urandom), ($urandom_range(0, 1) != 0) ? 3'd4 : 3'd0,
                           5'($urandom));
            end else begin
                ri = ($urandom_range(0, 1) != 0) ? 32'h0010_0073 : 32'h1050_0073;
            end
            applyStimulus(ri, {$urandom, $urandom}, {$urandom, $urandom} & ~64'h3,
                          $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
